exc_commit_seq: RTL

- Sequences the commit of a precise exception, interrupt or ERET raised in the M stage by the exception-type decoder.
- Drains any outstanding data-memory transaction, then issues a single-cycle commit:
  - CP0 update strobes (EPC, Cause.ExcCode/BD, Status.EXL, BadVAddr);
  - pipeline flush;
  - PC redirect.
- Afterwards it holds the flush for a fixed refill window.
- Sits between the exception decoder, CP0 and the hazard/PC-select logic.

---
 rtl/exc_commit_seq_pkg.sv | 40 ++++
 rtl/exc_cp0_encode.sv | 55 +++++
 rtl/exc_commit_seq.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/exc_commit_seq_pkg.sv
// Shared definitions for the exception commit sequencer: type codes, ExcCode values,
// the exception vector and the 2-bit state encoding.
package exc_commit_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_COMMIT = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    localparam logic [31:0] EXC_NONE = 32'h0;
    localparam logic [31:0] EXC_INT  = 32'h1;
    localparam logic [31:0] EXC_ADEL = 32'h4;
    localparam logic [31:0] EXC_ADES = 32'h5;
    localparam logic [31:0] EXC_SYS  = 32'h8;
    localparam logic [31:0] EXC_BP   = 32'h9;
    localparam logic [31:0] EXC_RI   = 32'ha;
    localparam logic [31:0] EXC_OV   = 32'hc;
    localparam logic [31:0] EXC_ERET = 32'he;

    localparam logic [4:0] EXCCODE_INT  = 5'h00;
    localparam logic [4:0] EXCCODE_ADEL = 5'h04;
    localparam logic [4:0] EXCCODE_ADES = 5'h05;
    localparam logic [4:0] EXCCODE_SYS  = 5'h08;
    localparam logic [4:0] EXCCODE_BP   = 5'h09;
    localparam logic [4:0] EXCCODE_RI   = 5'h0a;
    localparam logic [4:0] EXCCODE_OV   = 5'h0c;

    localparam logic [31:0] EXC_VECTOR = 32'hbfc00380;

    function automatic logic exc_is_valid(input logic [31:0] t);
        case (t)
            EXC_INT, EXC_ADEL, EXC_ADES, EXC_SYS, EXC_BP,
            EXC_RI, EXC_OV, EXC_ERET: exc_is_valid = 1'b1;
            default:                  exc_is_valid = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/exc_cp0_encode.sv
// Combinational mapping of a captured exception to CP0 update values
// (ExcCode, EPC, BadVAddr and EXL enables).
module exc_cp0_encode
    import exc_commit_seq_pkg::*;
(
    input  logic [31:0] exc_type,
    input  logic [31:0] pc,
    input  logic        bd,
    input  logic [31:0] vaddr,
    output logic [4:0]  exccode,
    output logic [31:0] epc,
    output logic        is_eret,
    output logic        exl_set,
    output logic        exl_clr,
    output logic        badvaddr_we,
    output logic [31:0] badvaddr
);

    // Delay-slot faults restart at the branch; the subtraction wraps modulo 2^32.
    assign epc = bd ? (pc - 32'd4) : pc;

    always_comb begin
        exccode     = exc_type[4:0];
        is_eret     = 1'b0;
        exl_set     = 1'b1;
        exl_clr     = 1'b0;
        badvaddr_we = 1'b0;
        badvaddr    = 32'h0;
        case (exc_type)
            EXC_INT:  exccode = EXCCODE_INT;
            EXC_ADEL: begin
                exccode     = EXCCODE_ADEL;
                badvaddr_we = 1'b1;
                badvaddr    = vaddr;
            end
            EXC_ADES: begin
                exccode     = EXCCODE_ADES;
                badvaddr_we = 1'b1;
                badvaddr    = vaddr;
            end
            EXC_SYS:  exccode = EXCCODE_SYS;
            EXC_BP:   exccode = EXCCODE_BP;
            EXC_RI:   exccode = EXCCODE_RI;
            EXC_OV:   exccode = EXCCODE_OV;
            EXC_ERET: begin
                exccode = 5'h0;
                is_eret = 1'b1;
                exl_set = 1'b0;
                exl_clr = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/exc_commit_seq.sv
// Precise exception/ERET commit sequencer: IDLE -> DRAIN -> COMMIT -> HOLD.
// Define EXC_COMMIT_PERF_EN to add exc_cnt_o / eret_cnt_o commit counters.
module exc_commit_seq
    import exc_commit_seq_pkg::*;
#(
    parameter int HOLD_CYCLES = 1,
    parameter int DRAIN_MAX   = 255
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] exc_type_i,
    input  logic [31:0] exc_pc_i,
    input  logic        exc_bd_i,
    input  logic [31:0] exc_vaddr_i,
    input  logic [31:0] pc_new_i,
    input  logic        mem_busy_i,
    output logic        stall_o,
    output logic        flush_o,
    output logic        redirect_o,
    output logic [31:0] redirect_pc_o,
    output logic        epc_we_o,
    output logic [31:0] epc_o,
    output logic        cause_we_o,
    output logic [4:0]  exccode_o,
    output logic        bd_o,
    output logic        exl_set_o,
    output logic        exl_clr_o,
    output logic        badvaddr_we_o,
    output logic [31:0] badvaddr_o,
    output logic        drain_timeout_o,
`ifdef EXC_COMMIT_PERF_EN
    output logic [31:0] exc_cnt_o,
    output logic [31:0] eret_cnt_o,
`endif
    output logic        busy_o
);

    state_t      state, state_nxt;
    logic [31:0] type_q, pc_q, vaddr_q, pcnew_q;
    logic        bd_q;
    logic [7:0]  dcnt;
    logic [3:0]  hcnt;
    logic        capture, drain_hit;

    logic [4:0]  enc_exccode;
    logic [31:0] enc_epc, enc_badvaddr;
    logic        enc_eret, enc_exl_set, enc_exl_clr, enc_badv_we;

    assign capture   = (state == ST_IDLE) && exc_is_valid(exc_type_i);
    assign drain_hit = (dcnt == 8'(DRAIN_MAX - 1));

    exc_cp0_encode u_enc (
        .exc_type    (type_q),
        .pc          (pc_q),
        .bd          (bd_q),
        .vaddr       (vaddr_q),
        .exccode     (enc_exccode),
        .epc         (enc_epc),
        .is_eret     (enc_eret),
        .exl_set     (enc_exl_set),
        .exl_clr     (enc_exl_clr),
        .badvaddr_we (enc_badv_we),
        .badvaddr    (enc_badvaddr)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (capture) state_nxt = mem_busy_i ? ST_DRAIN : ST_COMMIT;
            ST_DRAIN:  if (!mem_busy_i || drain_hit) state_nxt = ST_COMMIT;
            ST_COMMIT: state_nxt = ST_HOLD;
            ST_HOLD:   if (hcnt == 4'(HOLD_CYCLES - 1)) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        stall_o       = (state == ST_DRAIN);
        flush_o       = (state == ST_COMMIT) || (state == ST_HOLD);
        busy_o        = (state != ST_IDLE);
        redirect_o    = 1'b0;
        redirect_pc_o = 32'h0;
        epc_we_o      = 1'b0;
        epc_o         = 32'h0;
        cause_we_o    = 1'b0;
        exccode_o     = 5'h0;
        bd_o          = 1'b0;
        exl_set_o     = 1'b0;
        exl_clr_o     = 1'b0;
        badvaddr_we_o = 1'b0;
        badvaddr_o    = 32'h0;
        if (state == ST_COMMIT) begin
            redirect_o    = 1'b1;
            redirect_pc_o = pcnew_q;
            exl_set_o     = enc_exl_set;
            exl_clr_o     = enc_exl_clr;
            badvaddr_we_o = enc_badv_we;
            badvaddr_o    = enc_badvaddr;
            if (!enc_eret) begin
                epc_we_o   = 1'b1;
                epc_o      = enc_epc;
                cause_we_o = 1'b1;
                exccode_o  = enc_exccode;
                bd_o       = bd_q;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            type_q  <= 32'h0;
            pc_q    <= 32'h0;
            bd_q    <= 1'b0;
            vaddr_q <= 32'h0;
            pcnew_q <= 32'h0;
        end else if (capture) begin
            type_q  <= exc_type_i;
            pc_q    <= exc_pc_i;
            bd_q    <= exc_bd_i;
            vaddr_q <= exc_vaddr_i;
            pcnew_q <= pc_new_i;
        end
    end

    // Drain/hold counters restart on every entry into their state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dcnt            <= 8'h0;
            hcnt            <= 4'h0;
            drain_timeout_o <= 1'b0;
        end else begin
            dcnt <= (state == ST_DRAIN) ? dcnt + 8'd1 : 8'h0;
            hcnt <= (state == ST_HOLD)  ? hcnt + 4'd1 : 4'h0;
            if (state == ST_DRAIN && mem_busy_i && drain_hit)
                drain_timeout_o <= 1'b1;
        end
    end

`ifdef EXC_COMMIT_PERF_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            exc_cnt_o  <= 32'h0;
            eret_cnt_o <= 32'h0;
        end else if (state == ST_COMMIT) begin
            if (enc_eret) eret_cnt_o <= eret_cnt_o + 32'd1;
            else          exc_cnt_o  <= exc_cnt_o + 32'd1;
        end
    end
`endif

endmodule
